// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Default sizes and clear-engine state encoding.
package regfile_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector for RAW hazard detection.
// Lookups see a same-cycle writeback clear; allocs show next cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS = RF_NREGS,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_clr_en,
   input  logic [AW-1:0]     i_clr_addr,
   input  logic              i_set_en,
   input  logic [AW-1:0]     i_set_addr,
   input  logic [NRD*AW-1:0] i_rd_addr,
   output logic [NRD-1:0]    o_busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW-1:0]    ra;

   // Priority: flush, then writeback clear, then alloc set.
   always_comb begin
      busy_d = busy_q;
      if (i_flush) busy_d = '0;
      if (i_clr_en) busy_d[i_clr_addr] = 1'b0;
      if (i_set_en) busy_d[i_set_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   always_comb begin
      ra     = '0;
      o_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = i_rd_addr[k*AW +: AW];
         if (i_clr_en && (i_clr_addr == ra)) o_busy[k] = 1'b0;
         else                                o_busy[k] = busy_q[ra];
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// N-read/1-write register file with write-through bypass,
// busy scoreboard and a post-reset clear engine.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN  = RF_XLEN,
   parameter  int NREGS = RF_NREGS,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NRD*AW-1:0]   i_rs_addr,
   output logic [NRD*XLEN-1:0] o_rs_data,
   output logic [NRD-1:0]      o_rs_busy,
   input  logic                i_wr_en,
   input  logic [AW-1:0]       i_wr_addr,
   input  logic [XLEN-1:0]     i_wr_data,
   input  logic                i_alloc_en,
   input  logic [AW-1:0]       i_alloc_addr,
   input  logic                i_flush,
   output logic                o_ready
);

   rf_state_t       state_q;
   logic [AW-1:0]   cnt_q;
   logic            run;
   logic            wr_ok;
   logic [XLEN-1:0] regs [NREGS];
   logic [NRD-1:0]  sb_busy;
   logic [AW-1:0]   ra;

   assign run     = (state_q == RF_RUN);
   assign o_ready = run;
   assign wr_ok   = run && i_wr_en && (i_wr_addr != '0);

   // Clear engine: r1..r(NREGS-1), leaving INIT on the last write.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= RF_INIT;
         cnt_q   <= AW'(1);
      end else if (state_q == RF_INIT) begin
         cnt_q <= cnt_q + AW'(1);
         if (cnt_q == AW'(NREGS - 1)) state_q <= RF_RUN;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!run)       regs[cnt_q]     <= '0;
      else if (wr_ok) regs[i_wr_addr] <= i_wr_data;
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_sb (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_flush    (run && i_flush),
      .i_clr_en   (wr_ok),
      .i_clr_addr (i_wr_addr),
      .i_set_en   (run && i_alloc_en),
      .i_set_addr (i_alloc_addr),
      .i_rd_addr  (i_rs_addr),
      .o_busy     (sb_busy)
   );

   assign o_rs_busy = run ? sb_busy : '1;

   always_comb begin
      ra        = '0;
      o_rs_data = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = i_rs_addr[k*AW +: AW];
         if (run && (ra != '0)) begin
            if (wr_ok && (i_wr_addr == ra))
               o_rs_data[k*XLEN +: XLEN] = i_wr_data;
            else
               o_rs_data[k*XLEN +: XLEN] = regs[ra];
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: directed table, reset/INIT sequences,
// randomized traffic against a reference model, wide 4-port instance.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults (XLEN 32, NREGS 32, NRD 2)
   logic        rst = 1'b1;
   logic [9:0]  rs_addr = '0;
   logic [63:0] rs_data;
   logic [1:0]  rs_busy;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        alloc_en = 1'b0;
   logic [4:0]  alloc_addr = '0;
   logic        flush = 1'b0;
   logic        ready;

   regfile_mp_sb u_a (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_rs_addr    (rs_addr),
      .o_rs_data    (rs_data),
      .o_rs_busy    (rs_busy),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_alloc_en   (alloc_en),
      .i_alloc_addr (alloc_addr),
      .i_flush      (flush),
      .o_ready      (ready)
   );

   // Instance B: XLEN 64, NREGS 16, NRD 4
   logic         b_rst = 1'b1;
   logic [15:0]  b_rs_addr = '0;
   logic [255:0] b_rs_data;
   logic [3:0]   b_rs_busy;
   logic         b_wr_en = 1'b0;
   logic [3:0]   b_wr_addr = '0;
   logic [63:0]  b_wr_data = '0;
   logic         b_alloc_en = 1'b0;
   logic [3:0]   b_alloc_addr = '0;
   logic         b_flush = 1'b0;
   logic         b_ready;

   regfile_mp_sb #(
      .XLEN  (64),
      .NREGS (16),
      .NRD   (4)
   ) u_b (
      .i_clk        (clk),
      .i_reset      (b_rst),
      .i_rs_addr    (b_rs_addr),
      .o_rs_data    (b_rs_data),
      .o_rs_busy    (b_rs_busy),
      .i_wr_en      (b_wr_en),
      .i_wr_addr    (b_wr_addr),
      .i_wr_data    (b_wr_data),
      .i_alloc_en   (b_alloc_en),
      .i_alloc_addr (b_alloc_addr),
      .i_flush      (b_flush),
      .o_ready      (b_ready)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model for instance A
   logic [31:0] mregs [32];
   bit   [31:0] mbusy;
   bit          mready;
   int          init_left;

   function automatic logic [31:0] m_data(input logic [4:0] a);
      if (!mready || a == 0) return '0;
      if (wr_en && wr_addr == a) return wr_data;
      return mregs[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      if (!mready) return 1'b1;
      if (a == 0) return 1'b0;
      if (wr_en && wr_addr == a) return 1'b0;
      return mbusy[a];
   endfunction

   task automatic m_edge();
      if (rst) begin
         mready    = 1'b0;
         init_left = 31;
         mbusy     = '0;
         for (int i = 0; i < 32; i++) mregs[i] = '0;
      end else if (!mready) begin
         init_left--;
         if (init_left == 0) mready = 1'b1;
      end else begin
         if (flush) mbusy = '0;
         if (wr_en && wr_addr != 0) begin
            mregs[wr_addr] = wr_data;
            mbusy[wr_addr] = 1'b0;
         end
         if (alloc_en && alloc_addr != 0) mbusy[alloc_addr] = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic ae, input logic [4:0] aa,
                       input logic fl, input logic [4:0] a0,
                       input logic [4:0] a1);
      @(negedge clk);
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      alloc_en = ae; alloc_addr = aa; flush = fl;
      rs_addr = {a1, a0};
      #1;
      chk("ready", ready, mready);
      chk("rd_data", rs_data, {m_data(a1), m_data(a0)});
      chk("rd_busy", rs_busy, {m_busy(a1), m_busy(a0)});
      m_edge();
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ae;
      logic [4:0]  aa;
      logic        fl;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  b;
   } vec_t;

   vec_t tv [14];
   logic [63:0] bw;

   initial begin
      tv[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
      tv[1]  = '{0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
      tv[2]  = '{0, 0, 0, 1, 7, 0, 7, 5, 0, 32'hDEADBEEF, 2'b00};
      tv[3]  = '{0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b11};
      tv[4]  = '{1, 7, 32'h12, 0, 0, 0, 7, 7, 32'h12, 32'h12, 2'b00};
      tv[5]  = '{1, 3, 32'h55, 1, 3, 0, 3, 7, 32'h55, 32'h12, 2'b00};
      tv[6]  = '{1, 0, 32'hFFFF, 0, 0, 0, 0, 3, 0, 32'h55, 2'b10};
      tv[7]  = '{0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2'b00};
      tv[8]  = '{0, 0, 0, 1, 4, 0, 2, 3, 0, 32'h55, 2'b11};
      tv[9]  = '{0, 0, 0, 1, 6, 0, 2, 4, 0, 0, 2'b11};
      tv[10] = '{0, 0, 0, 1, 9, 1, 6, 9, 0, 0, 2'b01};
      tv[11] = '{0, 0, 0, 0, 0, 0, 2, 9, 0, 0, 2'b10};
      tv[12] = '{0, 0, 0, 0, 0, 0, 4, 6, 0, 0, 2'b00};
      tv[13] = '{0, 0, 0, 0, 0, 0, 3, 9, 32'h55, 0, 2'b10};

      // Reset and INIT timing
      repeat (2) @(posedge clk);
      m_edge();
      for (int i = 0; i < 31; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1, 31);
         chk("init_ready", ready, 1'b0);
         chk("init_busy", rs_busy, 2'b11);
         chk("init_data", rs_data, 64'h0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1, 31);
      chk("ready_32nd", ready, 1'b1);
      for (int r = 1; r < 32; r++) begin
         step(0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(r));
         chk("clear_data", rs_data, 64'h0);
         chk("clear_busy", rs_busy, 2'b00);
      end

      // Directed table
      for (int i = 0; i < 14; i++) begin
         step(0, tv[i].we, tv[i].wa, tv[i].wd, tv[i].ae, tv[i].aa,
              tv[i].fl, tv[i].a0, tv[i].a1);
         chk($sformatf("tv%0d_data", i), rs_data, {tv[i].d1, tv[i].d0});
         chk($sformatf("tv%0d_busy", i), rs_busy, tv[i].b);
      end

      // Reset mid-RUN
      step(0, 1, 10, 32'hA5, 1, 11, 0, 10, 11);
      step(0, 0, 0, 0, 0, 0, 0, 10, 11);
      chk("r10_pre", rs_data, {32'h0, 32'hA5});
      chk("r11_busy_pre", rs_busy, 2'b10);
      step(1, 0, 0, 0, 0, 0, 0, 10, 11);
      for (int i = 0; i < 31; i++) begin
         step(0, 1, 10, 32'h77, 1, 10, 1, 10, 11);
         chk("rerun_ready", ready, 1'b0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 10, 11);
      chk("rerun_ready_hi", ready, 1'b1);
      chk("rerun_r10", rs_data, 64'h0);
      chk("rerun_busy", rs_busy, 2'b00);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 249) == 0),
              1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)),
              ($urandom_range(0, 15) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      end

      // Wide 4-port instance
      @(negedge clk);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         chk("b_init_ready", b_ready, 1'b0);
         chk("b_init_busy", b_rs_busy, 4'hF);
         chk("b_init_data", b_rs_data, 256'h0);
         @(negedge clk);
      end
      #1;
      chk("b_ready_16th", b_ready, 1'b1);
      @(negedge clk);
      bw = 64'hA5A5_0123_4567_00A5;
      b_wr_en = 1'b1; b_wr_addr = 4'd10; b_wr_data = bw;
      b_rs_addr = {4{4'd10}};
      #1;
      chk("b_bypass", b_rs_data, {4{bw}});
      chk("b_bypass_busy", b_rs_busy, 4'h0);
      @(negedge clk);
      b_wr_en = 1'b0; b_alloc_en = 1'b1; b_alloc_addr = 4'd3;
      #1;
      chk("b_array", b_rs_data, {4{bw}});
      @(negedge clk);
      b_alloc_en = 1'b0;
      b_rs_addr = {4'd10, 4'd3, 4'd0, 4'd10};
      #1;
      chk("b_mix_data", b_rs_data, {bw, 64'h0, 64'h0, bw});
      chk("b_mix_busy", b_rs_busy, 4'b0100);
      @(negedge clk);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         chk("b_rerun_ready", b_ready, 1'b0);
         @(negedge clk);
      end
      #1;
      chk("b_rerun_ready_hi", b_ready, 1'b1);
      chk("b_rerun_data", b_rs_data, 256'h0);
      chk("b_rerun_busy", b_rs_busy, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
